// File: rtl/instr_fetch32.sv
// Minisys instruction fetch: PC register, req/ack instruction-memory fetch and next-PC selection.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned next PC raises a sticky fetch_fault and halts.
module instr_fetch32 #(
  parameter int unsigned ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       Instruction,
  output logic [5:0]        Opcode,
  output logic [5:0]        Function_opcode,
  output logic              inst_valid,
  input  logic              stall,
  input  logic              Branch,
  input  logic              nBranch,
  input  logic              Jmp,
  input  logic              Jal,
  input  logic              Jr,
  input  logic              Zero,
  input  logic [31:0]       Addr_result,
  input  logic [31:0]       Read_data_1,
  output logic [31:0]       branch_base_addr,
  output logic [31:0]       link_addr,
  output logic [31:0]       pc,
  output logic              fetch_fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] sel_pc;
  logic        branch_taken;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fault_q, fault_d;
`endif

  // Next-PC candidates, all derived from registered PC and instruction
  assign pc_plus4     = pc_q + 32'd4;
  assign jump_target  = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  assign branch_taken = (Branch && Zero) || (nBranch && !Zero);

  always_comb begin
    sel_pc = pc_plus4;
    if (Jr) begin
      sel_pc = Read_data_1;
    end else if (Jmp || Jal) begin
      sel_pc = jump_target;
    end else if (branch_taken) begin
      sel_pc = Addr_result;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef IFETCH_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
`ifdef IFETCH_ALIGN_CHECK_EN
          if (sel_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = sel_pc;
            state_d = S_REQ;
          end
`else
          pc_d    = sel_pc & 32'hFFFF_FFFC;
          state_d = S_REQ;
`endif
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // Request/valid decode straight from the state register so reset drops them at once
  assign imem_req         = (state_q == S_REQ);
  assign inst_valid       = (state_q == S_EXEC);
  assign imem_addr        = pc_q[ADDR_W+1:2];
  assign Instruction      = instr_q;
  assign Opcode           = instr_q[31:26];
  assign Function_opcode  = instr_q[5:0];
  assign pc               = pc_q;
  assign branch_base_addr = pc_plus4;
  assign link_addr        = pc_plus4;

endmodule

// File: doc/instr_fetch32.md
# instr_fetch32

Instruction fetch stage of the Minisys CPU. Holds the program counter, fetches words from a variable-latency instruction memory over a req/ack handshake, and presents the current instruction (Opcode, Function_opcode, jump index) to the control and decode stages. It computes the next PC from the branch and jump decisions returned by control and execute.

## Interface
- ADDR_W, 14, instruction-memory word-address width; imem_addr = PC[ADDR_W+1:2]
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  ADDR_W  word address, stable while imem_req=1
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- Instruction  out  32  latched instruction
- Opcode  out  6  Instruction[31:26]
- Function_opcode  out  6  Instruction[5:0]
- inst_valid  out  1  Instruction is current and executing
- stall  in  1  downstream hold; keeps the current instruction in execute
- Branch, nBranch, Jmp, Jal, Jr  in  1 each  decoded control signals
- Zero  in  1  ALU zero flag
- Addr_result  in  32  branch target from execute
- Read_data_1  in  32  rs value, the Jr target
- branch_base_addr  out  32  PC+4, sent to execute
- link_addr  out  32  PC+4, register write data for Jal
- pc  out  32  current PC
- fetch_fault  out  1  misaligned-target fault (see Configuration)

## Operation
- States: IDLE, REQ, EXEC, HALT. Reset forces IDLE.
- IDLE → REQ after one cycle.
- REQ: imem_req=1, imem_addr=PC[ADDR_W+1:2]. On imem_ack=1: latch imem_rdata into Instruction and go to EXEC. An ack in the same cycle the request is raised is accepted (zero-wait memory).
- EXEC: inst_valid=1.
  - While stall=1: hold state and Instruction; control inputs are ignored.
  - When stall=0: load PC with next_pc, go to REQ.
- next_pc priority, highest first:
  - Jr: Read_data_1
  - Jmp or Jal: {PC_plus4[31:28], Instruction[25:0], 2'b00}
  - Branch&&Zero or nBranch&&!Zero: Addr_result
  - otherwise: PC+4
- PC+4 is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- branch_base_addr and link_addr are both PC+4, combinational from the PC register.
- imem_ack outside REQ is ignored.

## Timing
- Reset values: PC=RESET_PC; Instruction=0; inst_valid=0; imem_req=0; fetch_fault=0; state IDLE.
- Asynchronous reset asserted mid-REQ drops imem_req in the same instant. No pending ack is honoured after reset.
- Minimum instruction period is 2 cycles (REQ with immediate ack, then EXEC). Each wait cycle on ack adds 1. Each stall cycle adds 1.
- Control inputs are sampled only on the EXEC cycle where stall=0. This is the only cycle PC changes.
- imem_addr and imem_req must not change while in REQ until ack.
- Opcode and Function_opcode change only on the cycle after an accepted ack.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined:
  - If the selected next_pc[1:0] != 0 on the EXEC exit cycle, PC is not updated.
  - fetch_fault goes to 1 and is sticky; state goes to HALT.
  - HALT: imem_req=0, inst_valid=0. Leave only by reset.
- IFETCH_ALIGN_CHECK_EN undefined:
  - next_pc[1:0] is forced to 00.
  - fetch_fault is tied to 0 and HALT is unreachable.

## Test plan
- Reset release, ack immediately in every REQ, no control asserted -> imem_addr sequence 0,1,2; pc sequence 0,4,8; inst_valid high every second cycle.
- imem_ack delayed 3 cycles -> imem_req and imem_addr held stable for 4 cycles; Instruction updates only after the ack.
- Instruction 32'h0800_0010 with Jmp=1 at pc=0x40 -> next pc=0x0000_0040. Jal=1 at pc=0x40 -> link_addr=0x44 during EXEC.
- Branch=1, Zero=1, Addr_result=0x100 -> pc=0x100. Branch=1, Zero=0 -> pc=PC+4. nBranch=1, Zero=0 -> pc=0x100.
- Jr=1 and Jmp=1 together, Read_data_1=0x200 -> pc=0x200 (Jr wins). stall=1 for 5 cycles in EXEC -> pc unchanged, inst_valid held.
- With IFETCH_ALIGN_CHECK_EN, Jr to 0x202 -> fetch_fault=1, pc unchanged, imem_req=0. Reset asserted mid-REQ -> imem_req=0 immediately, pc=0.
